dec_pend32: RTL and testbench

- Index-to-one-hot decoder with a registered 32-bit pending vector.
- Each cycle, one 5-bit index can be decoded and set, and one 5-bit index can be decoded and cleared.
- Produces the encoded-index side of the pend/service loop: producers post events by index; the downstream 32-to-5 priority encoder selects the next pending bit.
- Also keeps a running pending count and flags posts to an index that is already pending.

---
 rtl/dec_pend32.sv | 117 +++++++++++
 tb/tb_dec_pend32.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dec_pend32.sv
`default_nettype none
// ============================================================================
//  Module   : dec_pend32
//  Purpose  : Index-to-one-hot decoder feeding a registered 32-bit pending
//             vector. One index may be posted (set) and one serviced (cleared)
//             per cycle; clr_all drops everything. A set always wins over a
//             clear of the same bit, so a post racing a service is never lost.
//             Also tracks the pending count incrementally and flags posts to
//             an index that is already pending.
//  Ports    : clk, rst            clock, synchronous active-high reset
//             set_v, set_idx      set request valid / index
//             clr_v, clr_idx      clear request valid / index
//             clr_all             clear every pending bit (overrides clr_v)
//             pend                registered pending vector
//             set_oh              registered one-hot of accepted set (pulse)
//             any_pend            registered OR of pend
//             count               registered number of ones in pend (0..32)
//             dup                 registered pulse: set hit a still-pending bit
//  Revision : 1.0  initial release
// ============================================================================
module dec_pend32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_v,
  input  logic [4:0]  set_idx,
  input  logic        clr_v,
  input  logic [4:0]  clr_idx,
  input  logic        clr_all,
  output logic [31:0] pend,
  output logic [31:0] set_oh,
  output logic        any_pend,
  output logic [5:0]  count,
  output logic        dup
);

  localparam int N = 32;
  localparam int W = 5;
  localparam int CW = W + 1;

  logic [N-1:0]  pend_q, pend_d;
  logic [N-1:0]  set_oh_q, set_oh_d;
  logic          any_pend_q, any_pend_d;
  logic [CW-1:0] count_q, count_d;
  logic          dup_q, dup_d;

  logic [N-1:0]  s_oh;
  logic [N-1:0]  c_oh;
  logic          set_hit;   // set target is currently pending
  logic          inc;
  logic          dec;

  always_comb begin
    // Decodes are gated by their valids so an unknown index while idle
    // never reaches state.
    s_oh = '0;
    if (set_v) begin
      s_oh[set_idx] = 1'b1;
    end

    c_oh = '0;
    if (clr_all) begin
      c_oh = '1;
    end else if (clr_v) begin
      c_oh[clr_idx] = 1'b1;
    end

    pend_d   = (pend_q & ~c_oh) | s_oh;
    set_oh_d = s_oh;

    set_hit = 1'b0;
    dup_d   = 1'b0;
    if (set_v) begin
      set_hit = pend_q[set_idx];
      dup_d   = pend_q[set_idx] & ~c_oh[set_idx];
    end
    inc = set_v & ~set_hit;

    // Single-bit clear removes one only if the bit was pending and the same
    // cycle's set does not re-assert it.
    dec = 1'b0;
    if (clr_v) begin
      dec = pend_q[clr_idx] & ~s_oh[clr_idx];
    end

    if (clr_all) begin
      count_d = {{(CW-1){1'b0}}, set_v};
    end else begin
      count_d = count_q + {{(CW-1){1'b0}}, inc} - {{(CW-1){1'b0}}, dec};
    end

    any_pend_d = |pend_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      set_oh_q   <= '0;
      any_pend_q <= 1'b0;
      count_q    <= '0;
      dup_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      set_oh_q   <= set_oh_d;
      any_pend_q <= any_pend_d;
      count_q    <= count_d;
      dup_q      <= dup_d;
    end
  end

  assign pend     = pend_q;
  assign set_oh   = set_oh_q;
  assign any_pend = any_pend_q;
  assign count    = count_q;
  assign dup      = dup_q;

endmodule
`default_nettype wire

// File: tb/tb_dec_pend32.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dec_pend32
//  Purpose  : Self-checking bench for dec_pend32. Directed scenarios followed
//             by randomized set/clear traffic compared against a set-of-indices
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dec_pend32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        set_v = 1'b0;
  logic [4:0]  set_idx = '0;
  logic        clr_v = 1'b0;
  logic [4:0]  clr_idx = '0;
  logic        clr_all = 1'b0;
  logic [31:0] pend;
  logic [31:0] set_oh;
  logic        any_pend;
  logic [5:0]  count;
  logic        dup;

  int total = 0;
  int bad   = 0;

  // Reference model: membership per index, plus expected pulse outputs.
  bit          m_pend [32];
  bit [31:0]   m_set_oh;
  bit          m_dup;

  dec_pend32 u_dut (
    .clk      (clk),
    .rst      (rst),
    .set_v    (set_v),
    .set_idx  (set_idx),
    .clr_v    (clr_v),
    .clr_idx  (clr_idx),
    .clr_all  (clr_all),
    .pend     (pend),
    .set_oh   (set_oh),
    .any_pend (any_pend),
    .count    (count),
    .dup      (dup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] m_vec();
    bit [31:0] v = '0;
    for (int i = 0; i < 32; i++) if (m_pend[i]) v |= (32'd1 << i);
    return v;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) if (m_pend[i]) n++;
    return n;
  endfunction

  // Drive one cycle of inputs, advance the model, then compare all outputs.
  task automatic cyc(input bit r, input bit sv, input bit [4:0] si,
                     input bit cv, input bit [4:0] ci, input bit ca);
    bit cleared;
    rst = r; set_v = sv; set_idx = si; clr_v = cv; clr_idx = ci; clr_all = ca;
    if (r) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      m_set_oh = '0;
      m_dup    = 1'b0;
    end else begin
      cleared  = ca || (cv && ci == si);
      m_dup    = sv && m_pend[si] && !cleared;
      m_set_oh = sv ? (32'd1 << si) : 32'd0;
      if (ca) for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      else if (cv) m_pend[ci] = 1'b0;
      if (sv) m_pend[si] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("pend",     {32'd0, pend},      {32'd0, m_vec()});
    chk("set_oh",   {32'd0, set_oh},    {32'd0, m_set_oh});
    chk("any_pend", {63'd0, any_pend},  {63'd0, (m_count() != 0)});
    chk("count",    {58'd0, count},     64'(m_count()));
    chk("dup",      {63'd0, dup},       {63'd0, m_dup});
  endtask

  initial begin
    // Reset
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_pend", {32'd0, pend}, 64'h0);
    chk("rst_count", {58'd0, count}, 64'd0);

    // Post index 5
    cyc(0, 1, 5, 0, 0, 0);
    chk("set5_pend", {32'd0, pend}, 64'h20);
    chk("set5_oh", {32'd0, set_oh}, 64'h20);
    chk("set5_count", {58'd0, count}, 64'd1);
    chk("set5_any", {63'd0, any_pend}, 64'd1);
    chk("set5_dup", {63'd0, dup}, 64'd0);
    cyc(0, 0, 7, 0, 9, 0);
    chk("idle_oh", {32'd0, set_oh}, 64'h0);

    // Duplicate post
    cyc(0, 1, 5, 0, 0, 0);
    chk("dup5_dup", {63'd0, dup}, 64'd1);
    chk("dup5_count", {58'd0, count}, 64'd1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("dup_pulse_end", {63'd0, dup}, 64'd0);

    // Set 31 while servicing 5
    cyc(0, 1, 31, 1, 5, 0);
    chk("s31c5_pend", {32'd0, pend}, 64'h80000000);
    chk("s31c5_count", {58'd0, count}, 64'd1);

    // Clear of a non-pending bit: no effect
    cyc(0, 0, 0, 1, 12, 0);
    chk("clr_np_pend", {32'd0, pend}, 64'h80000000);

    // Set and clear same pending bit: set wins, count holds
    cyc(0, 1, 5, 0, 0, 0);
    cyc(0, 1, 5, 1, 5, 0);
    chk("sc5_pend", {32'd0, pend}, 64'h80000020);
    chk("sc5_count", {58'd0, count}, 64'd2);
    chk("sc5_dup", {63'd0, dup}, 64'd0);

    // Fill all 32
    for (int i = 0; i < 32; i++) cyc(0, 1, 5'(i), 0, 0, 0);
    chk("full_pend", {32'd0, pend}, 64'hFFFFFFFF);
    chk("full_count", {58'd0, count}, 64'd32);

    // clr_all with set_idx 0 (clr_v ignored)
    cyc(0, 1, 0, 1, 0, 1);
    chk("ca_pend", {32'd0, pend}, 64'h1);
    chk("ca_count", {58'd0, count}, 64'd1);
    chk("ca_any", {63'd0, any_pend}, 64'd1);
    cyc(0, 0, 0, 1, 9, 1);
    chk("ca_empty_any", {63'd0, any_pend}, 64'd0);

    // Reset overrides a set
    cyc(0, 1, 20, 0, 0, 0);
    cyc(1, 1, 3, 0, 0, 0);
    chk("rst_ovr_pend", {32'd0, pend}, 64'h0);
    chk("rst_ovr_oh", {32'd0, set_oh}, 64'h0);

    // Randomized traffic
    for (int n = 0; n < 10000; n++) begin
      int  r = $urandom_range(0, 999);
      bit  sv = ($urandom_range(0, 99) < 60);
      bit  cv = ($urandom_range(0, 99) < 45);
      bit  ca = (r < 15);
      bit  rr = (r >= 995);
      cyc(rr, sv, 5'($urandom), cv, 5'($urandom), ca);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
